// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the 5-stage core. It generates the load enables for
//   PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and the bubble/flush controls for
//   IF/ID and ID/EX. It handles three kinds of event:
//     - RAW hazards between the ID sources and the EX/MEM destinations,
//     - flushes caused by a taken branch or jump,
//     - waits on the data memory.
//   A RUN/WAIT/ERR state machine watches the memory handshake. If the wait
//   lasts too long the block enters ERR, which is sticky until reset.
//   Two saturating event counters are kept.
//
//   Optional feature macro: HAZARD_FORWARDING_EN
//     defined   : a forwarding unit exists, so only load-use dependencies stall.
//     undefined : any dependency on a pending EX or MEM writer stalls until
//                 that writer has left MEM.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   id_rs1_i, id_rs2_i          source register addresses of the ID instruction
//   id_use_rs1_i, id_use_rs2_i  the ID instruction really reads rs1 / rs2
//   ex_rd_i, ex_reg_write_i     EX destination and its register-write flag
//   ex_mem_re_i                 the EX instruction is a load
//   mem_rd_i, mem_reg_write_i   MEM destination and its register-write flag
//   ex_branch_taken_i           branch/jump resolved taken in EX
//   mem_req_i, mem_ready_i      data-memory request / completion
//   pc_en_o .. mem_wb_en_o      stage load enables
//   if_id_flush_o, id_ex_flush_o  load a NOP bubble into that register
//   mem_err_o                   sticky memory-timeout error
//   stall_cnt_o                 cycles with pc_en_o=0 outside ERR (saturating)
//   flush_cnt_o                 taken-branch flush events (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_re_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic              ex_branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              id_ex_en_o,
    output logic              ex_mem_en_o,
    output logic              mem_wb_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Source/destination comparison. Register 0 is hard-wired and never
    // creates a dependency.
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] src_rs  [2];
    logic [1:0]        src_use;
    logic [1:0]        match_ex;
    logic [1:0]        match_mem;

    assign src_rs[0]  = id_rs1_i;
    assign src_rs[1]  = id_rs2_i;
    assign src_use[0] = id_use_rs1_i;
    assign src_use[1] = id_use_rs2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign match_ex[gi]  = src_use[gi] && (src_rs[gi] == ex_rd_i)
                                   && (ex_rd_i != '0);
            assign match_mem[gi] = src_use[gi] && (src_rs[gi] == mem_rd_i)
                                   && (mem_rd_i != '0);
        end
    endgenerate

    logic load_use;
    logic hazard;

    assign load_use = ex_mem_re_i && (|match_ex);

`ifdef HAZARD_FORWARDING_EN
    // Forwarding resolves every RAW case except a load result needed at once.
    assign hazard = load_use;
    logic unused_fwd;
    assign unused_fwd = ^{ex_reg_write_i, mem_reg_write_i, match_mem};
`else
    // Without forwarding, the ID instruction waits until every pending writer
    // of its sources has retired. The register file writes before it reads,
    // so a writer in WB no longer needs a stall.
    assign hazard = load_use
                  || (ex_reg_write_i  && (|match_ex))
                  || (mem_reg_write_i && (|match_mem));
`endif

    // ------------------------------------------------------------------
    // Stage controls. The priority order is ERR > freeze > branch > hazard > run.
    // ------------------------------------------------------------------
    logic freeze;
    logic branch_fire;

    assign freeze = ((state_q == ST_WAIT) && !mem_ready_i)
                 || ((state_q == ST_RUN) && mem_req_i && !mem_ready_i);

    assign branch_fire = !reset && (state_q != ST_ERR) && !freeze
                      && ex_branch_taken_i;

    always_comb begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_en_o    = 1'b0;
        ex_mem_en_o   = 1'b0;
        mem_wb_en_o   = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (reset || (state_q == ST_ERR) || freeze) begin
            // Everything is held. A taken branch in EX stays in place and
            // fires once the pipeline moves again.
        end else if (ex_branch_taken_i) begin
            // The branch wins over a load-use stall: the dependent instruction
            // in ID is on the wrong path and is squashed.
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            id_ex_en_o    = 1'b1;
            ex_mem_en_o   = 1'b1;
            mem_wb_en_o   = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (hazard) begin
            // Hold PC and IF/ID. Put a bubble into ID/EX and let the older
            // instructions drain.
            id_ex_en_o    = 1'b1;
            id_ex_flush_o = 1'b1;
            ex_mem_en_o   = 1'b1;
            mem_wb_en_o   = 1'b1;
        end else begin
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            id_ex_en_o    = 1'b1;
            ex_mem_en_o   = 1'b1;
            mem_wb_en_o   = 1'b1;
        end
    end

    assign mem_err_o   = (state_q == ST_ERR);
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // ------------------------------------------------------------------
    // Next state, memory-wait timer and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                // If mem_ready arrives in the last allowed cycle, the access
                // completes normally and no error is raised.
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_ERR;
        endcase

        if (!pc_en_o && (state_q != ST_ERR) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_fire && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Table-driven bench for hazard_ctrl. The counters are narrowed to 4 bits so
//   that saturation can be reached. Each stimulus record pushes its expected
//   outputs into a scoreboard queue. Half a cycle later the record is popped
//   and compared with the combinational outputs and the counters.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
    logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_re;
    logic          mem_reg_write, ex_branch_taken, mem_req, mem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(CW), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rd_i(ex_rd), .ex_reg_write_i(ex_reg_write), .ex_mem_re_i(ex_mem_re),
        .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
        .ex_branch_taken_i(ex_branch_taken),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
        .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .mem_err_o(mem_err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Enable vectors are ordered {pc, if_id, id_ex, ex_mem, mem_wb}.
    // Flush vectors are ordered {if_id, id_ex}.
    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_HAZ  = 5'b00111;
    localparam logic [1:0] FL_NO   = 2'b00;
    localparam logic [1:0] FL_HAZ  = 2'b01;
    localparam logic [1:0] FL_BR   = 2'b11;
`ifdef HAZARD_FORWARDING_EN
    localparam logic [4:0] EN_RAW = EN_ALL;
    localparam logic [1:0] FL_RAW = FL_NO;
`else
    localparam logic [4:0] EN_RAW = EN_HAZ;
    localparam logic [1:0] FL_RAW = FL_HAZ;
`endif

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] ex_rd;
        logic       ex_rw;
        logic       ex_re;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] en;
        logic [1:0] fl;
        logic       err;
    } vec_t;

    typedef struct {
        string         name;
        logic [4:0]    en;
        logic [1:0]    fl;
        logic          err;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    vec_t          tbl[$];
    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    function automatic vec_t mk(input string n,
                                input logic [4:0] rs1, input logic use1,
                                input logic [4:0] rs2, input logic use2,
                                input logic [4:0] exrd, input logic exrw,
                                input logic exre,
                                input logic [4:0] memrd, input logic memrw,
                                input logic br, input logic req, input logic rdy,
                                input logic [4:0] en, input logic [1:0] fl,
                                input logic err);
        vec_t v;
        v.name = n;    v.rs1 = rs1;     v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
        v.ex_rd = exrd; v.ex_rw = exrw; v.ex_re = exre;
        v.mem_rd = memrd; v.mem_rw = memrw;
        v.br = br; v.req = req; v.rdy = rdy;
        v.en = en; v.fl = fl; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // One clock cycle: drive the vector, record its expectation, then sample
    // the outputs on the falling edge.
    task automatic run_vec(input vec_t v);
        exp_t e, g;
        @(posedge clk);
        #1;
        id_rs1 = v.rs1;   id_use_rs1 = v.use1;
        id_rs2 = v.rs2;   id_use_rs2 = v.use2;
        ex_rd = v.ex_rd;  ex_reg_write = v.ex_rw; ex_mem_re = v.ex_re;
        mem_rd = v.mem_rd; mem_reg_write = v.mem_rw;
        ex_branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
        e.name = v.name; e.en = v.en; e.fl = v.fl; e.err = v.err;
        e.stall = m_stall; e.flush = m_flush;
        exp_q.push_back(e);
        // This cycle's event is counted on the next rising edge.
        if (!v.en[4] && !v.err && m_stall != '1) m_stall = m_stall + 1'b1;
        if (v.fl == FL_BR && m_flush != '1)      m_flush = m_flush + 1'b1;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({v.name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            chk({g.name, " en"},    {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                {27'd0, g.en});
            chk({g.name, " flush"}, {30'd0, if_id_flush, id_ex_flush}, {30'd0, g.fl});
            chk({g.name, " err"},   {31'd0, mem_err}, {31'd0, g.err});
            chk({g.name, " stall_cnt"}, {28'd0, stall_cnt}, {28'd0, g.stall});
            chk({g.name, " flush_cnt"}, {28'd0, flush_cnt}, {28'd0, g.flush});
            $display("[TB] %s: en=%b fl=%b err=%b stall=%0d flush=%0d", g.name,
                     {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                     {if_id_flush, id_ex_flush}, mem_err, stall_cnt, flush_cnt);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " en"},    {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'd0);
        chk({nm, " flush"}, {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk({nm, " err"},   {31'd0, mem_err}, 32'd0);
        chk({nm, " stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
        chk({nm, " flush_cnt"}, {28'd0, flush_cnt}, 32'd0);
    endtask

    initial begin
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_reg_write = 0; ex_mem_re = 0;
        mem_reg_write = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;

        //            name           rs1 u1 rs2 u2 exrd rw re memrd rw br rq rdy en  fl  err
        tbl.push_back(mk("run",        1, 1, 2, 1,  3, 1, 0,  4, 1, 0, 0, 0, EN_ALL, FL_NO,  0));
        tbl.push_back(mk("lduse_rs1",  5, 1, 0, 0,  5, 1, 1,  0, 0, 0, 0, 0, EN_HAZ, FL_HAZ, 0));
        tbl.push_back(mk("lduse_rs2",  1, 1, 5, 1,  5, 1, 1,  0, 0, 0, 0, 0, EN_HAZ, FL_HAZ, 0));
        tbl.push_back(mk("rs2_unused", 1, 1, 5, 0,  5, 1, 1,  0, 0, 0, 0, 0, EN_ALL, FL_NO,  0));
        tbl.push_back(mk("x0_load",    0, 1, 0, 1,  0, 1, 1,  0, 1, 0, 0, 0, EN_ALL, FL_NO,  0));
        tbl.push_back(mk("br_lduse",   5, 1, 0, 0,  5, 1, 1,  0, 0, 1, 0, 0, EN_ALL, FL_BR,  0));
        tbl.push_back(mk("raw_ex_x7",  7, 1, 0, 0,  7, 1, 0,  0, 0, 0, 0, 0, EN_RAW, FL_RAW, 0));
        tbl.push_back(mk("raw_mem_x7", 7, 1, 0, 0,  0, 0, 0,  7, 1, 0, 0, 0, EN_RAW, FL_RAW, 0));
        tbl.push_back(mk("raw_done",   7, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, EN_ALL, FL_NO,  0));
        tbl.push_back(mk("raw_mem_r2", 1, 1, 9, 1,  0, 0, 0,  9, 1, 0, 0, 0, EN_RAW, FL_RAW, 0));
        tbl.push_back(mk("mem_x0",     0, 1, 0, 1,  0, 1, 0,  0, 1, 0, 0, 0, EN_ALL, FL_NO,  0));
        tbl.push_back(mk("mem_fast",   1, 1, 0, 0,  2, 1, 0,  3, 1, 0, 1, 1, EN_ALL, FL_NO,  0));

        // Reset state, checked asynchronously before the first edge.
        #3;
        chk_reset_outputs("reset_hold");
        #9 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // A 3-cycle memory wait. The taken branch is held during the wait and
        // fires on the cycle the access completes.
        for (int i = 0; i < 3; i++)
            run_vec(mk("wait3", 5, 1, 0, 0, 5, 1, 1, 0, 0, 1, 1, 0, EN_NONE, FL_NO, 0));
        run_vec(mk("wait3_done", 5, 1, 0, 0, 5, 1, 1, 0, 0, 1, 1, 1, EN_ALL, FL_BR, 0));
        run_vec(mk("after_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO, 0));

        // mem_ready arrives in the last allowed WAIT cycle, so there is no error.
        run_vec(mk("tmo_edge_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NO, 0));
        for (int i = 0; i < 14; i++)
            run_vec(mk("tmo_edge_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NO, 0));
        run_vec(mk("tmo_edge_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EN_ALL, FL_NO, 0));
        run_vec(mk("tmo_edge_ok",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO, 0));

        // Timeout: one RUN freeze cycle plus 15 WAIT cycles, then sticky ERR.
        run_vec(mk("tmo_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NO, 0));
        for (int i = 0; i < 15; i++)
            run_vec(mk("tmo_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NO, 0));
        run_vec(mk("err_sticky",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EN_NONE, FL_NO, 1));
        run_vec(mk("err_branch",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EN_NONE, FL_NO, 1));
        run_vec(mk("err_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_NONE, FL_NO, 1));

        // Asynchronous reset pulse clears ERR and the counters.
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("reset_pulse");
        @(negedge clk);
        reset = 1'b0;
        m_stall = '0;
        m_flush = '0;
        run_vec(mk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO, 0));
        run_vec(mk("post_lduse", 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, EN_HAZ, FL_HAZ, 0));
        run_vec(mk("post_branch", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EN_ALL, FL_BR, 0));
        run_vec(mk("post_final", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
